// File: rtl/mips_pkg.sv
// mips_pkg: shared encodings for the multicycle MIPS controller.
// Holds the FSM state enum, opcode/funct values, ALU control codes,
// the controller-to-aludec ALU operation class and mux-select codes.
package mips_pkg;

  typedef enum logic [4:0] {
    S_FETCH1  = 5'd0,
    S_FETCH2  = 5'd1,
    S_FETCH3  = 5'd2,
    S_FETCH4  = 5'd3,
    S_DECODE  = 5'd4,
    S_MEMADR  = 5'd5,
    S_LBRD    = 5'd6,
    S_LBWR    = 5'd7,
    S_SBWR    = 5'd8,
    S_RTYPEEX = 5'd9,
    S_RTYPEWR = 5'd10,
    S_BEQEX   = 5'd11,
    S_JEX     = 5'd12,
    S_ADDIEX  = 5'd13,
    S_ADDIWR  = 5'd14
  } state_t;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU control codes
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALU operation class from FSM to aludec. NONE keeps alucontrol at its
  // all-zero default in states that do not use the ALU.
  localparam logic [1:0] ALUOP_NONE  = 2'b00;
  localparam logic [1:0] ALUOP_ADD   = 2'b01;
  localparam logic [1:0] ALUOP_SUB   = 2'b10;
  localparam logic [1:0] ALUOP_FUNCT = 2'b11;

  // ALU B-operand select
  localparam logic [1:0] SRCB_B   = 2'b00;
  localparam logic [1:0] SRCB_ONE = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;
  localparam logic [1:0] SRCB_OFF = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/controller_aludec.sv
// aludec: combinational ALU decoder.
// Ports:
//   aluop      in  2  operation class from the controller FSM
//   funct      in  6  instr[5:0], used only for the R-type class
//   alucontrol out 3  ALU operation code
module aludec
  import mips_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_AND;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;  // includes FN_ADD
        endcase
      end
      default: alucontrol = ALU_AND;
    endcase
  end

endmodule

// File: rtl/controller.sv
// controller: multicycle Moore control FSM for the 8-bit MIPS datapath.
// Fetches each instruction as four byte reads, decodes op, then
// sequences the datapath through execute/memory/writeback states.
// Ports:
//   clk, reset (async active-low)
//   op, funct, zero            from datapath
//   memread, memwrite          memory strobes
//   alusrca, alusrcb, iord     datapath mux selects
//   irwrite                    one-hot instruction byte load
//   memtoreg, regdst, regwrite register file write path
//   pcen, pcsource             PC update
//   alucontrol                 ALU operation
module controller
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       memread,
  output logic       memwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       iord,
  output logic [3:0] irwrite,
  output logic       memtoreg,
  output logic       regdst,
  output logic       regwrite,
  output logic       pcen,
  output logic [1:0] pcsource,
  output logic [2:0] alucontrol
);

  state_t     state_reg, state_next;
  logic       memread_raw, memwrite_raw, regwrite_raw, pcwrite, branch;
  logic [3:0] irwrite_raw;
  logic [1:0] aluop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= S_FETCH1;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = S_FETCH1;
    case (state_reg)
      S_FETCH1: state_next = S_FETCH2;
      S_FETCH2: state_next = S_FETCH3;
      S_FETCH3: state_next = S_FETCH4;
      S_FETCH4: state_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LB, OP_SB: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_RTYPEEX;
          OP_BEQ:       state_next = S_BEQEX;
          OP_J:         state_next = S_JEX;
          OP_ADDI:      state_next = S_ADDIEX;
          default:      state_next = S_FETCH1;  // unknown op executes as a no-op
        endcase
      end
      S_MEMADR: begin
        if (op == OP_LB)      state_next = S_LBRD;
        else if (op == OP_SB) state_next = S_SBWR;
        else                  state_next = S_FETCH1;
      end
      S_LBRD:    state_next = S_LBWR;
      S_RTYPEEX: state_next = S_RTYPEWR;
      S_ADDIEX:  state_next = S_ADDIWR;
      default:   state_next = S_FETCH1;  // last state of each instruction, or illegal encoding
    endcase
  end

  always_comb begin
    memread_raw  = 1'b0;
    memwrite_raw = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = SRCB_B;
    iord         = 1'b0;
    irwrite_raw  = 4'b0000;
    memtoreg     = 1'b0;
    regdst       = 1'b0;
    regwrite_raw = 1'b0;
    pcwrite      = 1'b0;
    branch       = 1'b0;
    pcsource     = PCSRC_ALU;
    aluop        = ALUOP_NONE;
    case (state_reg)
      S_FETCH1, S_FETCH2, S_FETCH3, S_FETCH4: begin
        memread_raw = 1'b1;
        iord        = 1'b1;
        alusrca     = 1'b1;
        alusrcb     = SRCB_ONE;
        aluop       = ALUOP_ADD;
        pcwrite     = 1'b1;
        // state index 0..3 selects the instruction byte being loaded
        irwrite_raw = 4'b0001 << state_reg[1:0];
      end
      S_DECODE: begin
        // precompute branch target into aluout
        alusrca = 1'b1;
        alusrcb = SRCB_OFF;
        aluop   = ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        alusrcb = SRCB_IMM;
        aluop   = ALUOP_ADD;
      end
      S_LBRD: memread_raw = 1'b1;
      S_LBWR: begin
        regwrite_raw = 1'b1;
        regdst       = 1'b1;
      end
      S_SBWR: memwrite_raw = 1'b1;
      S_RTYPEEX: aluop = ALUOP_FUNCT;
      S_RTYPEWR: begin
        regwrite_raw = 1'b1;
        memtoreg     = 1'b1;
      end
      S_BEQEX: begin
        aluop    = ALUOP_SUB;
        branch   = 1'b1;
        pcsource = PCSRC_ALUOUT;
      end
      S_JEX: begin
        pcwrite  = 1'b1;
        pcsource = PCSRC_JUMP;
      end
      S_ADDIWR: begin
        regwrite_raw = 1'b1;
        regdst       = 1'b1;
        memtoreg     = 1'b1;
      end
      default: ;
    endcase
  end

  aludec u_aludec (
    .aluop      (aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

  // Strobes are gated by reset so nothing is written while reset is held,
  // even though the FETCH1 state itself would drive them.
  assign memread  = memread_raw  & reset;
  assign memwrite = memwrite_raw & reset;
  assign regwrite = regwrite_raw & reset;
  assign irwrite  = reset ? irwrite_raw : 4'b0000;
  assign pcen     = reset & (pcwrite | (branch & zero));

endmodule

// File: tb/tb_controller.sv
module tb_controller;

  logic       clk, reset;
  logic [5:0] op, funct;
  logic       zero;
  logic       memread, memwrite, alusrca, iord, memtoreg, regdst, regwrite, pcen;
  logic [1:0] alusrcb, pcsource;
  logic [3:0] irwrite;
  logic [2:0] alucontrol;

  controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .memread(memread), .memwrite(memwrite), .alusrca(alusrca), .alusrcb(alusrcb),
    .iord(iord), .irwrite(irwrite), .memtoreg(memtoreg), .regdst(regdst),
    .regwrite(regwrite), .pcen(pcen), .pcsource(pcsource), .alucontrol(alucontrol)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // packed output word: {memread, memwrite, alusrca, alusrcb, iord, irwrite,
  //                      memtoreg, regdst, regwrite, pcen, pcsource, alucontrol}
  typedef struct {
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic [18:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  function automatic logic [18:0] ow(input logic mr, input logic mw, input logic sa,
                                     input logic [1:0] sb, input logic io,
                                     input logic [3:0] irw, input logic mtr,
                                     input logic rd, input logic rw, input logic pe,
                                     input logic [1:0] ps, input logic [2:0] ac);
    return {mr, mw, sa, sb, io, irw, mtr, rd, rw, pe, ps, ac};
  endfunction

  function automatic logic [18:0] act_word();
    return {memread, memwrite, alusrca, alusrcb, iord, irwrite,
            memtoreg, regdst, regwrite, pcen, pcsource, alucontrol};
  endfunction

  task automatic check(input string name, input logic [18:0] act, input logic [18:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %b, expected %b", name, act, exp);
  endtask

  task automatic push(input logic [5:0] o, input logic [5:0] f, input logic z,
                      input logic [18:0] e, input string n);
    vec_t v;
    v.op = o; v.funct = f; v.zero = z; v.exp = e; v.name = n;
    vecs.push_back(v);
  endtask

  task automatic push_fetch(input logic [5:0] o, input logic [5:0] f, input logic z,
                            input string tag);
    logic [3:0] irw;
    for (int i = 0; i < 4; i++) begin
      irw = 4'b0001 << i;
      push(o, f, z, ow(1, 0, 1, 2'b01, 1, irw, 0, 0, 0, 1, 2'b00, 3'b010),
           $sformatf("%s_fetch%0d", tag, i + 1));
    end
    push(o, f, z, ow(0, 0, 1, 2'b11, 0, 4'b0, 0, 0, 0, 0, 2'b00, 3'b010), {tag, "_decode"});
  endtask

  task automatic push_rtype(input logic [5:0] f, input logic [2:0] ac, input string tag);
    push_fetch(6'b000000, f, 1'b1, tag);
    push(6'b000000, f, 1'b1, ow(0, 0, 0, 2'b00, 0, 4'b0, 0, 0, 0, 0, 2'b00, ac), {tag, "_ex"});
    push(6'b000000, f, 1'b1, ow(0, 0, 0, 2'b00, 0, 4'b0, 1, 0, 1, 0, 2'b00, 3'b000), {tag, "_wr"});
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  logic [18:0] fetch1_w, fetch2_w, fetch1_rst_w;
  int          pcw_cnt;

  initial begin
    reset = 1'b0; op = 6'b0; funct = 6'b0; zero = 1'b0;
    fetch1_w     = ow(1, 0, 1, 2'b01, 1, 4'b0001, 0, 0, 0, 1, 2'b00, 3'b010);
    fetch2_w     = ow(1, 0, 1, 2'b01, 1, 4'b0010, 0, 0, 0, 1, 2'b00, 3'b010);
    fetch1_rst_w = ow(0, 0, 1, 2'b01, 1, 4'b0000, 0, 0, 0, 0, 2'b00, 3'b010);

    // RTYPE with every funct class
    push_rtype(6'b100010, 3'b110, "sub");
    push_rtype(6'b100000, 3'b010, "add");
    push_rtype(6'b100100, 3'b000, "and");
    push_rtype(6'b100101, 3'b001, "or");
    push_rtype(6'b101010, 3'b111, "slt");
    push_rtype(6'b111111, 3'b010, "rdflt");
    // BEQ taken / not taken
    push_fetch(6'b000100, 6'b0, 1'b1, "beqT");
    push(6'b000100, 6'b0, 1'b1, ow(0, 0, 0, 2'b00, 0, 4'b0, 0, 0, 0, 1, 2'b01, 3'b110), "beqT_ex");
    push_fetch(6'b000100, 6'b0, 1'b0, "beqN");
    push(6'b000100, 6'b0, 1'b0, ow(0, 0, 0, 2'b00, 0, 4'b0, 0, 0, 0, 0, 2'b01, 3'b110), "beqN_ex");
    // LB
    push_fetch(6'b100000, 6'b0, 1'b1, "lb");
    push(6'b100000, 6'b0, 1'b1, ow(0, 0, 0, 2'b10, 0, 4'b0, 0, 0, 0, 0, 2'b00, 3'b010), "lb_memadr");
    push(6'b100000, 6'b0, 1'b1, ow(1, 0, 0, 2'b00, 0, 4'b0, 0, 0, 0, 0, 2'b00, 3'b000), "lb_rd");
    push(6'b100000, 6'b0, 1'b1, ow(0, 0, 0, 2'b00, 0, 4'b0, 0, 1, 1, 0, 2'b00, 3'b000), "lb_wr");
    // SB
    push_fetch(6'b101000, 6'b0, 1'b0, "sb");
    push(6'b101000, 6'b0, 1'b0, ow(0, 0, 0, 2'b10, 0, 4'b0, 0, 0, 0, 0, 2'b00, 3'b010), "sb_memadr");
    push(6'b101000, 6'b0, 1'b0, ow(0, 1, 0, 2'b00, 0, 4'b0, 0, 0, 0, 0, 2'b00, 3'b000), "sb_wr");
    // ADDI
    push_fetch(6'b001000, 6'b0, 1'b1, "addi");
    push(6'b001000, 6'b0, 1'b1, ow(0, 0, 0, 2'b10, 0, 4'b0, 0, 0, 0, 0, 2'b00, 3'b010), "addi_ex");
    push(6'b001000, 6'b0, 1'b1, ow(0, 0, 0, 2'b00, 0, 4'b0, 1, 1, 1, 0, 2'b00, 3'b000), "addi_wr");
    // unknown op: DECODE then straight back to FETCH1
    push_fetch(6'b111111, 6'b0, 1'b1, "nop");
    // back-to-back J
    for (int k = 0; k < 2; k++) begin
      push_fetch(6'b000010, 6'b0, 1'b0, $sformatf("j%0d", k));
      push(6'b000010, 6'b0, 1'b0, ow(0, 0, 0, 2'b00, 0, 4'b0, 0, 0, 0, 1, 2'b10, 3'b000),
           $sformatf("j%0d_ex", k));
    end
    push(6'b000000, 6'b0, 1'b0, fetch1_w, "final_fetch1");

    // reset state
    #12;
    check("reset_state", act_word(), fetch1_rst_w);
    reset = 1'b1;

    // table: one check per cycle; the next instruction's fetch1 entry also
    // verifies the cycle count of the previous one
    foreach (vecs[i]) begin
      op = vecs[i].op; funct = vecs[i].funct; zero = vecs[i].zero;
      #1;
      check(vecs[i].name, act_word(), vecs[i].exp);
      $display("vec %0d %s op=%b funct=%b zero=%b out=%b", i, vecs[i].name,
               op, funct, zero, act_word());
      step();
    end
    // now in FETCH2 of the final fetch; drain to FETCH1 via the nop path
    op = 6'b111111;
    repeat (4) step();

    // pcwrite count across two back-to-back J instructions
    op = 6'b000010; zero = 1'b1;
    pcw_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (pcen && pcsource == 2'b00) pcw_cnt++;
      step();
    end
    total_cnt++;
    if (pcw_cnt == 8) pass_cnt++;
    else $display("FAIL jj_pcwrite_count: got %0d, expected 8", pcw_cnt);
    $display("jj pcwrite count=%0d", pcw_cnt);

    // reset during LBRD
    op = 6'b100000; zero = 1'b0;
    repeat (6) step();
    check("lbrd_before_reset", act_word(),
          ow(1, 0, 0, 2'b00, 0, 4'b0, 0, 0, 0, 0, 2'b00, 3'b000));
    reset = 1'b0;
    #1;
    check("reset_mid_lbrd", act_word(), fetch1_rst_w);
    step();
    check("reset_held_edge", act_word(), fetch1_rst_w);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("release_fetch1", act_word(), fetch1_w);
    step();
    check("release_fetch2", act_word(), fetch2_w);
    $display("reset sequence done");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
